// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-to-binary arbiter: FSM state encoding and
// the round-robin winner search used in IDLE.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IDW  = 3;

    // First set bit of valid at or after ptr, wrapping nreq-1 -> 0.
    // Returns 0 when nothing is set; callers qualify with |valid.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  ptr,
        input int unsigned         nreq
    );
        logic [MAX_IDW-1:0] win;
        logic               found;
        int unsigned        idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (!found && (k < nreq) && valid[idx[MAX_IDW-1:0]]) begin
                win   = idx[MAX_IDW-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/gray2bin_w.sv
// Combinational Gray-to-binary converter of parameterised width.
// Ports: gray (Gray-coded input word), bin (binary output word).
module gray2bin_w #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_bin_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter among
// NREQ requesters, one conversion in flight at a time.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   req_valid/req_gray  per-requester request and packed Gray words
//   req_ready           one-hot accept strobe (combinational, IDLE only)
//   out_valid/out_ready result handshake towards the consumer
//   out_bin/out_id      converted word and index of the served requester
//   busy                FSM is not in IDLE
module gray_bin_arbiter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_bin,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] gray_q;
    logic [IDW-1:0]   id_q;

    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;
    logic [WIDTH-1:0] sel_gray;
    logic [WIDTH-1:0] conv_bin;
    logic             grant;

    // Winner search and accept qualification; no grant while reset is held.
    assign winner   = IDW'(rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(rr_ptr), NREQ));
    assign grant    = !rst && (state == IDLE) && (|req_valid);
    assign sel_gray = req_gray[int'(winner)*int'(WIDTH) +: WIDTH];
    assign next_ptr = (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);

    // One-hot accept strobe.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    gray2bin_w #(.WIDTH(WIDTH)) u_conv (
        .gray (gray_q),
        .bin  (conv_bin)
    );

    // FSM, priority pointer, capture and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gray_q    <= '0;
            id_q      <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gray_q <= sel_gray;
                        id_q   <= winner;
                        rr_ptr <= next_ptr;
                        state  <= CONV;
                        busy   <= 1'b1;
                    end
                end
                CONV: begin
                    out_bin   <= conv_bin;
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_bin_arbiter.sv
// Randomised scoreboard bench for gray_bin_arbiter.
module tb_gray_bin_arbiter;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_gray;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_bin;
    logic [IDW-1:0]        out_id;
    logic                  busy;

    gray_bin_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH+IDW-1:0] exp_q[$];
    int   g2b_tab[1<<WIDTH];
    int   m_ptr;
    bit   m_free;
    bit   m_free_next;
    int   m_age;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            int idx;
            idx = (ptr + k) % int'(NREQ);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] pack(input int g0, input int g1, input int g2, input int g3);
        logic [NREQ*WIDTH-1:0] p;
        p = '0;
        p[0*WIDTH +: WIDTH] = WIDTH'(g0);
        p[1*WIDTH +: WIDTH] = WIDTH'(g1);
        p[2*WIDTH +: WIDTH] = WIDTH'(g2);
        p[3*WIDTH +: WIDTH] = WIDTH'(g3);
        return p;
    endfunction

    // One clock of stimulus with model update and handshake-side checks.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] g, input logic ordy);
        logic [NREQ-1:0]  exp_rdy;
        logic             exp_ov;
        logic [WIDTH-1:0] gw;
        int               w;
        @(negedge clk);
        req_valid = v;
        req_gray  = g;
        out_ready = ordy;
        #1;
        if (m_free_next) begin
            m_free      = 1'b1;
            m_free_next = 1'b0;
        end
        check("busy", 32'(busy), 32'(!m_free));
        exp_ov  = 1'b0;
        exp_rdy = '0;
        if (!m_free) begin
            m_age++;
            if (m_age >= 2) begin
                exp_ov = 1'b1;
                if (ordy) m_free_next = 1'b1;
            end
        end
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (m_free && (|v)) begin
            w          = pick(v, m_ptr);
            exp_rdy[w] = 1'b1;
            gw         = g[w*WIDTH +: WIDTH];
            exp_q.push_back({WIDTH'(g2b_tab[gw]), IDW'(w)});
            m_ptr      = (w + 1) % int'(NREQ);
            m_free     = 1'b0;
            m_age      = 0;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
    endtask

    // Assert reset for n cycles; in-flight work is dropped.
    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_free      = 1'b1;
        m_free_next = 1'b0;
        m_ptr       = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        repeat (n) @(negedge clk);
        check("rst_hold_req_ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
    endtask

    // Monitor: compares presented results against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got bin=%0h id=%0d expected none", out_bin, out_id);
                end else begin
                    check("out_bin", 32'(out_bin), 32'(exp_q[0][IDW +: WIDTH]));
                    check("out_id", 32'(out_id), 32'(exp_q[0][IDW-1:0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int b = 0; b < (1 << WIDTH); b++) g2b_tab[b ^ (b >> 1)] = b;
        rst         = 1'b1;
        req_valid   = '0;
        req_gray    = '0;
        out_ready   = 1'b0;
        m_ptr       = 0;
        m_free      = 1'b1;
        m_free_next = 1'b0;
        m_age       = 0;

        // Power-on reset with no requests.
        apply_reset(2);
        idle(3);

        // Single requester 2, gray 110 -> binary 100, id 2.
        cycle(4'b0100, pack(0, 0, 6, 0), 1'b1);
        idle(4);

        // All requesting: rotation 0,1,2,3,0.
        apply_reset(1);
        for (int i = 0; i < 20; i++) cycle(4'b1111, pack(0, 1, 3, 2), 1'b1);
        idle(4);

        // Backpressure with gray 111 held in OUT.
        cycle(4'b0001, pack(7, 0, 0, 0), 1'b1);
        for (int i = 0; i < 7; i++) cycle(4'b0001, pack(7, 0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0001, pack(7, 0, 0, 0), 1'b1);
        idle(5);

        // Pointer wrap: grant 2 sets ptr to 3, then 1001 grants 3 then 0.
        apply_reset(1);
        cycle(4'b0100, pack(0, 0, 5, 0), 1'b1);
        idle(4);
        for (int i = 0; i < 8; i++) cycle(4'b1001, pack(2, 0, 0, 4), 1'b1);
        for (int i = 0; i < 8; i++) cycle(4'b0001, pack(3, 0, 0, 0), 1'b1);
        idle(4);

        // Reset during CONV with gray 100 in flight.
        cycle(4'b0001, pack(4, 0, 0, 0), 1'b1);
        apply_reset(1);
        idle(4);

        // Every Gray code through requester 1.
        for (int g = 0; g < (1 << WIDTH); g++) begin
            cycle(4'b0010, pack(0, g, 0, 0), 1'b1);
            idle(3);
        end

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                  (NREQ*WIDTH)'($urandom),
                  ($urandom_range(0, 3) != 0));
            if (i == 1000) apply_reset(2);
        end
        idle(10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
